// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// FSM state encoding and default operation latencies.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs mult/div for a fixed
// latency and requests a D-stage stall while HI/LO are in flux.
module md_sequencer
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDOp,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_IsMD,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic        D_MDStall
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    md_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   hi, hi_n, lo, lo_n;
    logic [31:0]   pend_hi, pend_hi_n, pend_lo, pend_lo_n;
    logic          pend_vld, pend_vld_n;

    md_op_t        op;
    logic          is_start;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   divisor;
    logic signed [31:0] sa, sd, quo_s, rem_s;
    logic [31:0]   quo_u, rem_u;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            pend_hi  <= '0;
            pend_lo  <= '0;
            pend_vld <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hi       <= hi_n;
            lo       <= lo_n;
            pend_hi  <= pend_hi_n;
            pend_lo  <= pend_lo_n;
            pend_vld <= pend_vld_n;
        end
    end

    always_comb begin
        op       = md_op_t'(E_MDOp);
        is_start = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);

        prod_s  = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
        prod_u  = {32'd0, E_A} * {32'd0, E_B};
        // Zero divisor is replaced so the dividers never see it; the result is discarded anyway.
        divisor = (E_B == '0) ? 32'd1 : E_B;
        sa      = $signed(E_A);
        sd      = $signed(divisor);
        quo_s   = sa / sd;
        rem_s   = sa % sd;
        quo_u   = E_A / divisor;
        rem_u   = E_A % divisor;

        state_n    = state;
        cnt_n      = cnt;
        hi_n       = hi;
        lo_n       = lo;
        pend_hi_n  = pend_hi;
        pend_lo_n  = pend_lo;
        pend_vld_n = pend_vld;

        case (state)
            IDLE: begin
                case (op)
                    MD_MULT: begin
                        {pend_hi_n, pend_lo_n} = prod_s;
                        pend_vld_n = 1'b1;
                        cnt_n      = CW'(MULT_CYCLES);
                        state_n    = RUN;
                    end
                    MD_MULTU: begin
                        {pend_hi_n, pend_lo_n} = prod_u;
                        pend_vld_n = 1'b1;
                        cnt_n      = CW'(MULT_CYCLES);
                        state_n    = RUN;
                    end
                    MD_DIV: begin
                        pend_hi_n  = rem_s;
                        pend_lo_n  = quo_s;
                        pend_vld_n = (E_B != '0);
                        cnt_n      = CW'(DIV_CYCLES);
                        state_n    = RUN;
                    end
                    MD_DIVU: begin
                        pend_hi_n  = rem_u;
                        pend_lo_n  = quo_u;
                        pend_vld_n = (E_B != '0);
                        cnt_n      = CW'(DIV_CYCLES);
                        state_n    = RUN;
                    end
                    MD_MTHI: hi_n = E_A;
                    MD_MTLO: lo_n = E_A;
                    default: ;
                endcase
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    if (pend_vld) begin
                        hi_n = pend_hi;
                        lo_n = pend_lo;
                    end
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign E_Busy    = (state == RUN);
    assign E_HI      = hi;
    assign E_LO      = lo;
    assign D_MDStall = D_IsMD && (E_Busy || is_start);

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the E stage of the five-stage pipeline. It accepts one HI/LO operation per cycle from E, runs multiplies and divides for a fixed latency, and owns the HI and LO registers. It raises a D-stage stall toward the hazard logic whenever the instruction in D needs HI/LO while the unit is busy or starting.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- E_MDOp  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- E_A  in  32  rs operand, already forwarded
- E_B  in  32  rt operand, already forwarded
- D_IsMD  in  1  instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- E_Busy  out  1  operation in progress
- E_HI  out  32  HI register
- E_LO  out  32  LO register
- D_MDStall  out  1  stall request for D

## Operation
- States: IDLE, RUN.
- IDLE, E_MDOp in 1..4: latch the result (HI and LO computed from E_A/E_B at issue) into pending registers; load the counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- mult: signed 32×32→64; HI = [63:32], LO = [31:0]. multu: unsigned.
- div: signed; LO = quotient truncated toward zero, HI = remainder with sign of dividend. divu: unsigned.
- Divide by zero (E_B = 0): full latency runs; HI/LO left unchanged at commit.
- IDLE, E_MDOp 5/6: HI (mthi) or LO (mtlo) ← E_A at that edge; no busy cycle.
- RUN: decrement counter each cycle; at the edge where counter = 1, commit pending to HI/LO, return to IDLE.
- Any E_MDOp ≠ 0 arriving in RUN is ignored (hazard contract makes it impossible; bench asserts it never occurs).
- E_Busy = (state == RUN).
- D_MDStall = D_IsMD && (E_Busy || E_MDOp in 1..4); combinational.
- mfhi/mflo read E_HI/E_LO combinationally; no sequencer action.

## Timing
- Reset values: state IDLE, counter 0, HI = 0, LO = 0, pending = 0, E_Busy = 0; D_MDStall follows its equation (0 unless D_IsMD and an E start).
- Start sampled at edge t → E_Busy high for cycles t+1 … t+N (N = MULT_CYCLES/DIV_CYCLES); new HI/LO visible from cycle t+N+1, same cycle E_Busy falls.
- A new start may issue in the first cycle after E_Busy falls (back-to-back, no gap).
- mthi/mtlo: value visible the cycle after issue.
- reset asserted mid-RUN: operation abandoned, HI/LO = 0, no commit.
- Operands are not required to hold after issue.

## Structure
- Shared package md_pkg: op encoding constants (MD_NONE … MD_MTLO), state encoding, default latencies.
- Single module; no sub-module needed. Counter width = $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

## Test plan
- Reset: reset=0 mid-operation → E_HI = E_LO = 0, E_Busy = 0 immediately.
- mult A=0xFFFFFFFF, B=2 → E_Busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 → E_Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 → LO=3, HI=1.
- div A=5, B=0 after mthi 0x1234/mtlo 0x5678 → 10 busy cycles, HI=0x1234, LO=0x5678 unchanged.
- Stall: D_IsMD=1 during issue cycle and all busy cycles → D_MDStall=1 exactly 1+N cycles; D_IsMD=0 → never stalls.
- Back-to-back: multu issued the cycle E_Busy falls → second result correct, first result visible for exactly 6 cycles (commit cycle + 5 busy cycles) before the second commit.
